// File: rtl/s3_timer_pkg.sv
// Shared definitions for the S3 fabric timer blocks: state encoding and default width.
package s3_timer_pkg;

   localparam int W_DEF = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

endpackage : s3_timer_pkg

// File: rtl/s3_dec8.sv
// 8-bit combinational decrementer, x = a - 1 modulo 256; companion of s3_inc8.
module s3_dec8 (
   input  logic [7:0] a,
   output logic [7:0] x
);

   assign x = a - 8'd1;

endmodule : s3_dec8

// File: rtl/s3_dcnt8.sv
// Loadable down-counter/timer: counts the reload period in ce ticks and pulses tc at terminal
// count, either once (one-shot) or periodically (auto-reload).
module s3_dcnt8
   import s3_timer_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         start,
   input  logic         stop,
   input  logic         auto_reload,
   input  logic         ce,
   output logic [W-1:0] count,
   output logic         busy,
   output logic         tc,
   output logic         start_err
);

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   state_e         state_q, state_d;
   logic [W-1:0]   count_q, count_d;
   logic [W-1:0]   rld_q, rld_d;
   logic           tc_q, tc_d;
   logic           err_q, err_d;

   logic [W-1:0]   eff_rld;
   logic           eff_zero;
   logic           count_is_one;
   logic           count_gt_one;
   logic [W-1:0]   dec_val;

   // A load in the same cycle as start is already the period the start uses.
   assign eff_rld      = load ? load_val : rld_q;
   assign eff_zero     = (eff_rld == '0);
   assign count_is_one = (count_q == ONE);
   assign count_gt_one = (count_q > ONE);

   generate
      if (W == 8) begin : g_dec8
         s3_dec8 u_dec (
            .a (count_q),
            .x (dec_val)
         );
      end else begin : g_dec_generic
         assign dec_val = count_q - ONE;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         rld_q   <= '0;
         tc_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         rld_q   <= rld_d;
         tc_q    <= tc_d;
         err_q   <= err_d;
      end
   end

   // Priority: stop > start > ce countdown.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start && !eff_zero) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (start) begin
               if (eff_zero) begin
                  state_d = ST_IDLE;
               end
            end else if (ce && count_is_one && !auto_reload) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      count_d = count_q;
      rld_d   = load ? load_val : rld_q;
      tc_d    = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (load) begin
               count_d = load_val;
            end
            if (start) begin
               if (eff_zero) begin
                  err_d = 1'b1;
               end else begin
                  count_d = eff_rld;
               end
            end
         end
         ST_RUN: begin
            if (stop) begin
               count_d = count_q;
            end else if (start) begin
               if (eff_zero) begin
                  err_d = 1'b1;
               end else begin
                  count_d = eff_rld;
               end
            end else if (ce) begin
               if (count_is_one) begin
                  // Reload uses the captured period; a same-cycle load applies from the next one.
                  tc_d    = 1'b1;
                  count_d = auto_reload ? rld_q : '0;
               end else if (count_gt_one) begin
                  count_d = dec_val;
               end
            end
         end
         default: count_d = count_q;
      endcase
   end

   assign count     = count_q;
   assign busy      = (state_q == ST_RUN);
   assign tc        = tc_q;
   assign start_err = err_q;

endmodule : s3_dcnt8

// File: tb/tb_s3_dcnt8.sv
// Bench for s3_dcnt8: directed scenarios with hand-derived expectations plus a randomized run
// against a cycle-level behavioural model; s3_dec8 is also swept exhaustively.
module tb_s3_dcnt8;

   logic       clk;
   logic       rst;
   logic       load;
   logic [7:0] load_val;
   logic       start;
   logic       stop;
   logic       auto_reload;
   logic       ce;
   logic [7:0] count;
   logic       busy;
   logic       tc;
   logic       start_err;

   logic [7:0] dec_a;
   logic [7:0] dec_x;

   int n_checks = 0;
   int n_errors = 0;

   // behavioural model state
   int m_count = 0;
   int m_rld   = 0;
   bit m_run   = 0;
   bit m_tc    = 0;
   bit m_err   = 0;

   s3_dcnt8 #(.W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .load        (load),
      .load_val    (load_val),
      .start       (start),
      .stop        (stop),
      .auto_reload (auto_reload),
      .ce          (ce),
      .count       (count),
      .busy        (busy),
      .tc          (tc),
      .start_err   (start_err)
   );

   s3_dec8 u_dec (
      .a (dec_a),
      .x (dec_x)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock of the timer's rules, evaluated on the inputs present at the edge.
   task automatic model_step();
      int eff;
      int n_count;
      int n_rld;
      bit n_run;
      bit n_tc;
      bit n_err;
      if (rst) begin
         m_count = 0; m_rld = 0; m_run = 0; m_tc = 0; m_err = 0;
         return;
      end
      eff     = load ? int'(load_val) : m_rld;
      n_rld   = eff;
      n_count = m_count;
      n_run   = m_run;
      n_tc    = 0;
      n_err   = 0;
      if (!m_run) begin
         if (load) n_count = load_val;
         if (start) begin
            if (eff == 0) n_err = 1;
            else begin n_count = eff; n_run = 1; end
         end
      end else if (stop) begin
         n_run = 0;
      end else if (start) begin
         if (eff == 0) begin n_err = 1; n_run = 0; end
         else n_count = eff;
      end else if (ce) begin
         if (m_count == 1) begin
            n_tc = 1;
            if (auto_reload) n_count = m_rld;
            else begin n_count = 0; n_run = 0; end
         end else if (m_count > 1) begin
            n_count = (m_count - 1) % 256;
         end
      end
      m_count = n_count; m_rld = n_rld; m_run = n_run; m_tc = n_tc; m_err = n_err;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      load = 0; load_val = 0; start = 0; stop = 0; auto_reload = 0; ce = 0; rst = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      tick();
      rst = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      tick();
      tick();
      n_checks++;
      if ({count, busy, tc, start_err} !== 11'h0) begin
         n_errors++;
         $display("FAIL reset: count=%0d busy=%0b tc=%0b err=%0b, required all 0", count, busy, tc, start_err);
      end
      rst = 0;
   endtask

   task automatic test_one_shot();
      int exp_count;
      do_reset();
      load = 1; load_val = 8'd5;
      tick();
      load = 0;
      n_checks++;
      if (count !== 8'd5 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL one_shot_load: count=%0d busy=%0b, required 5 0", count, busy);
      end
      start = 1; ce = 1; auto_reload = 0;
      tick();
      start = 0;
      for (int k = 0; k < 9; k++) begin
         exp_count = (5 - k > 0) ? 5 - k : 0;
         n_checks++;
         if (count !== 8'(exp_count) || tc !== (k == 5) || busy !== (k < 5)) begin
            n_errors++;
            $display("FAIL one_shot cyc%0d: count=%0d tc=%0b busy=%0b, required %0d %0b %0b",
                     k + 1, count, tc, busy, exp_count, (k == 5), (k < 5));
         end
         tick();
      end
   endtask

   task automatic test_auto_reload();
      int pulses;
      int last;
      int seq_err;
      do_reset();
      load = 1; load_val = 8'd3;
      tick();
      load = 0; auto_reload = 1; start = 1; ce = 0;
      tick();
      start = 0;
      pulses = 0; last = -1; seq_err = 0;
      for (int i = 0; i < 24; i++) begin
         ce = (i % 2 == 0);
         tick();
         if (busy !== 1'b1) seq_err++;
         if ({count, busy, tc, start_err} !== {8'(m_count), m_run, m_tc, m_err}) seq_err++;
         if (tc === 1'b1) begin
            if (count !== 8'd3) seq_err++;
            if (last >= 0 && i - last != 6) seq_err++;
            last = i;
            pulses++;
         end
      end
      n_checks++;
      if (pulses != 4 || seq_err != 0) begin
         n_errors++;
         $display("FAIL auto_reload: pulses=%0d bad_cycles=%0d, required 4 0", pulses, seq_err);
      end
      ce = 0; auto_reload = 0;
   endtask

   task automatic test_zero_period();
      do_reset();
      start = 1; ce = 1;
      tick();
      start = 0;
      n_checks++;
      if (start_err !== 1'b1 || busy !== 1'b0 || tc !== 1'b0) begin
         n_errors++;
         $display("FAIL zero_start: err=%0b busy=%0b tc=%0b, required 1 0 0", start_err, busy, tc);
      end
      tick();
      n_checks++;
      if (start_err !== 1'b0 || busy !== 1'b0 || tc !== 1'b0) begin
         n_errors++;
         $display("FAIL zero_after: err=%0b busy=%0b tc=%0b, required 0 0 0", start_err, busy, tc);
      end
      load = 1; load_val = 8'd9;
      tick();
      load = 1; load_val = 8'd0; start = 1;
      tick();
      load = 0; start = 0;
      n_checks++;
      if (start_err !== 1'b1 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL zero_load_start: err=%0b busy=%0b, required 1 0", start_err, busy);
      end
      ce = 0;
   endtask

   task automatic test_load_start();
      do_reset();
      load = 1; load_val = 8'h02; start = 1; ce = 0;
      tick();
      load = 0; start = 0;
      n_checks++;
      if (count !== 8'd2 || busy !== 1'b1) begin
         n_errors++;
         $display("FAIL load_start: count=%0d busy=%0b, required 2 1", count, busy);
      end
      ce = 1;
      tick();
      tick();
      n_checks++;
      if (tc !== 1'b1 || count !== 8'd0 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL load_start_tc: tc=%0b count=%0d busy=%0b, required 1 0 0", tc, count, busy);
      end
      ce = 0;
   endtask

   task automatic test_collisions();
      do_reset();
      load = 1; load_val = 8'd3;
      tick();
      load = 0; start = 1; ce = 1;
      tick();
      start = 0;
      tick();
      tick();
      stop = 1;
      tick();
      stop = 0;
      n_checks++;
      if (tc !== 1'b0 || busy !== 1'b0 || count !== 8'd1) begin
         n_errors++;
         $display("FAIL stop_at_tc: tc=%0b busy=%0b count=%0d, required 0 0 1", tc, busy, count);
      end
      start = 1;
      tick();
      start = 0;
      tick();
      tick();
      start = 1;
      tick();
      start = 0;
      n_checks++;
      if (tc !== 1'b0 || busy !== 1'b1 || count !== 8'd3) begin
         n_errors++;
         $display("FAIL start_at_tc: tc=%0b busy=%0b count=%0d, required 0 1 3", tc, busy, count);
      end
      tick();
      n_checks++;
      if (tc !== 1'b0 || count !== 8'd2) begin
         n_errors++;
         $display("FAIL start_at_tc_next: tc=%0b count=%0d, required 0 2", tc, count);
      end
      ce = 0;
   endtask

   task automatic test_midrun_load();
      int gap;
      do_reset();
      load = 1; load_val = 8'd4;
      tick();
      load = 0; auto_reload = 1; start = 1; ce = 1;
      tick();
      start = 0;
      tick();
      load = 1; load_val = 8'd7;
      tick();
      load = 0;
      n_checks++;
      if (count !== 8'd2) begin
         n_errors++;
         $display("FAIL midrun_load_count: count=%0d, required 2", count);
      end
      tick();
      tick();
      n_checks++;
      if (tc !== 1'b1 || count !== 8'd7) begin
         n_errors++;
         $display("FAIL midrun_first_tc: tc=%0b count=%0d, required 1 7", tc, count);
      end
      gap = 0;
      for (int i = 1; i <= 20 && gap == 0; i++) begin
         tick();
         if (tc === 1'b1) gap = i;
      end
      n_checks++;
      if (gap != 7) begin
         n_errors++;
         $display("FAIL midrun_period: period=%0d, required 7", gap);
      end
      ce = 0; auto_reload = 0;
   endtask

   task automatic test_rst_mid_run();
      int guard;
      do_reset();
      load = 1; load_val = 8'd5;
      tick();
      load = 0; start = 1; ce = 1;
      tick();
      start = 0;
      guard = 0;
      while (count !== 8'd2 && guard < 20) begin
         tick();
         guard++;
      end
      rst = 1;
      tick();
      rst = 0;
      n_checks++;
      if (guard >= 20 || {count, busy, tc, start_err} !== 11'h0) begin
         n_errors++;
         $display("FAIL rst_mid_run: count=%0d busy=%0b tc=%0b guard=%0d, required 0 0 0", count, busy, tc, guard);
      end
      tick();
      n_checks++;
      if (tc !== 1'b0 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL rst_mid_run_after: tc=%0b busy=%0b, required 0 0", tc, busy);
      end
      ce = 0;
   endtask

   task automatic test_dec_exhaustive();
      int bad;
      logic [7:0] want;
      bad = 0;
      for (int a = 0; a < 256; a++) begin
         dec_a = 8'(a);
         #1;
         want = 8'((a + 255) % 256);
         if (dec_x !== want) begin
            bad++;
            if (bad < 5) $display("FAIL dec8 a=%0d: x=%0d, required %0d", a, dec_x, want);
         end
      end
      n_checks++;
      if (bad != 0) begin
         n_errors++;
         $display("FAIL dec8_sweep: wrong=%0d, required 0", bad);
      end
   endtask

   task automatic test_random();
      int bad;
      logic [10:0] exp_v;
      do_reset();
      bad = 0;
      for (int i = 0; i < 3000; i++) begin
         rst         = ($urandom_range(0, 299) == 0);
         load        = ($urandom_range(0, 15) == 0);
         load_val    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
         start       = ($urandom_range(0, 19) == 0);
         stop        = ($urandom_range(0, 39) == 0);
         ce          = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 49) == 0) auto_reload = ~auto_reload;
         tick();
         exp_v = {8'(m_count), m_run, m_tc, m_err};
         n_checks++;
         if ({count, busy, tc, start_err} !== exp_v) begin
            n_errors++;
            bad++;
            if (bad < 10)
               $display("FAIL random cyc%0d: count=%0d busy=%0b tc=%0b err=%0b, required %0d %0b %0b %0b",
                        i, count, busy, tc, start_err, m_count, m_run, m_tc, m_err);
         end
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      dec_a = 8'd0;
      rst = 1;
      @(negedge clk);
      test_reset();
      test_one_shot();
      test_auto_reload();
      test_zero_period();
      test_load_start();
      test_collisions();
      test_midrun_load();
      test_rst_mid_run();
      test_dec_exhaustive();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_s3_dcnt8

// File: doc/s3_dcnt8.md
Name: s3_dcnt8

Overview:
- Loadable 8-bit down-counter/timer for the EOS S3 fabric, built around a decrement datapath.
- Counts a programmed period down in ce ticks and emits a one-cycle terminal-count pulse.
- Runs in one-shot or auto-reload mode.
- Used as a programmable tick/timeout source for fabric peripherals.

Parameters:
W, 8, counter and reload width in bits

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
load  in  1  strobe: capture load_val into reload register
load_val  in  W  period value, in ce ticks
start  in  1  strobe: begin or restart counting
stop  in  1  strobe: abort counting, return to IDLE
auto_reload  in  1  1 = periodic mode, 0 = one-shot; sampled at terminal count
ce  in  1  count enable (prescaler tick)
count  out  W  current counter value (registered)
busy  out  1  1 while in RUN
tc  out  1  one-cycle terminal-count pulse (registered)
start_err  out  1  one-cycle pulse: start rejected because reload value is 0

Behaviour:
- Reset: state=IDLE, rld=0, count=0, busy=0, tc=0, start_err=0.
- States: IDLE, RUN. busy = (state==RUN), registered.
- tc and start_err default to 0 every cycle; they are set only as listed below.
- load (any state): rld <= load_val next cycle.
  - In IDLE, count <= load_val as well.
  - In RUN, count is unchanged; the new rld takes effect at the next reload or restart.
- start in IDLE:
  - If effective rld != 0: count <= rld, state <= RUN.
  - If effective rld == 0: stay IDLE, start_err <= 1.
  - Effective rld = load_val if load is asserted the same cycle, else rld. load and start together use the new value.
- start in RUN: restart. count <= effective rld; stays RUN; no tc. If effective rld == 0, behave as stop and pulse start_err.
- RUN with ce=1:
  - count > 1: count <= count-1, computed by the s3_dec8 instance.
  - count == 1: tc <= 1 (visible the next cycle).
    - auto_reload=1: count <= rld, stay RUN.
    - auto_reload=0: count <= 0, state <= IDLE.
- RUN with ce=0: hold count.
- Period: exactly rld ce-ticks between consecutive tc pulses in auto-reload mode.
- One-shot latency: with ce held high, tc is asserted N+1 cycles after the start cycle (N = rld); busy deasserts in the same cycle tc asserts.
- Priority, highest first: rst > stop > start > ce countdown.
  - stop in the same cycle as a would-be terminal count: no tc, count holds, state <= IDLE.
  - stop in IDLE: no effect.
- Arithmetic:
  - Decrement is modulo 2^W and is never applied at count==0; there is no wrap in normal operation.
  - rld=255 gives a 255-tick period.
- Reset asserted mid-RUN: all outputs return to reset values the next cycle, and any pending tc is discarded.

Decomposition:
- Shared package s3_timer_pkg: state encoding constants ST_IDLE=1'b0, ST_RUN=1'b1; W default.
- Sub-module s3_dec8 (combinational, ports a[7:0] -> x[7:0], x = a-1 mod 256). It mirrors s3_inc8's interface and is to be verified exhaustively on its own.

Test Plan:
- Basic one-shot: load_val=5 + load, then start, ce=1, auto_reload=0 -> count 5,4,3,2,1,0; tc high exactly once, 6 cycles after start; busy falls with tc; count stays 0.
- Auto-reload with prescale: rld=3, auto_reload=1, ce high 1 cycle in 2 -> tc every 6 clk cycles; count sequence 3,2,1,3,2,1...; 4 pulses checked; busy stays 1.
- Zero period: rld=0, start -> start_err pulse 1 cycle, busy=0, tc never.
- Same-cycle start+load: load_val=0x02 with load and start together -> count=2 next cycle, tc after 2 ce ticks.
- Collisions:
  - stop on the cycle count==1 with ce=1 -> no tc, busy=0, count=1.
  - start on that cycle instead -> count=rld, no tc.
- Mid-run changes:
  - load of 7 during RUN with rld=4, auto_reload=1 -> current period completes at 4, next period is 7.
  - rst asserted at count=2 -> count=0, busy=0, tc=0 next cycle.
  - Exhaustive s3_dec8: a=0..255 vs a-1 mod 256, err never set.
